// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and serial frame bit values.
// Imported by the receiver and by anything that needs the frame convention.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam logic START_BIT   = 1'b0;
  localparam logic STOP_BIT    = 1'b1;
  // Even parity: the parity bit makes the total count of ones (data + parity) even.
  localparam logic PARITY_EVEN = 1'b1;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: the serial input line plus the parallel byte and status.
// The receiver uses the slave view; whoever drives the line and consumes bytes uses master.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);

  logic                 RXdataIn;
  logic [DATA_BITS-1:0] dataOut;
  logic                 RXdone;
  logic                 parityError;
  logic                 framingError;
  logic                 RXbusy;

  modport slave (
    input  RXdataIn,
    output dataOut,
    output RXdone,
    output parityError,
    output framingError,
    output RXbusy
  );

  modport master (
    output RXdataIn,
    input  dataOut,
    input  RXdone,
    input  parityError,
    input  framingError,
    input  RXbusy
  );

endinterface

// File: rtl/rx_bit_timer.sv
// Oversampling tick counter for the receiver: counts up every clk2 unless cleared,
// and flags the mid-bit (half period) and end-of-bit (full period) positions.
module rx_bit_timer #(
  parameter int OVERSAMPLE = 8,
  parameter int TICK_W     = $clog2(OVERSAMPLE)
) (
  input  logic clk2,
  input  logic reset,
  input  logic i_clr,
  output logic o_half_tick,
  output logic o_full_tick
);

  localparam logic [TICK_W-1:0] HALF_VAL = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_VAL = TICK_W'(OVERSAMPLE - 1);

  logic [TICK_W-1:0] r_tick;

  // The owner always clears at or before FULL_VAL, so the counter never wraps on its own.
  always_ff @(posedge clk2 or negedge reset) begin
    if (!reset) begin
      r_tick <= '0;
    end else if (i_clr) begin
      r_tick <= '0;
    end else begin
      r_tick <= r_tick + 1'b1;
    end
  end

  assign o_half_tick = (r_tick == HALF_VAL);
  assign o_full_tick = (r_tick == FULL_VAL);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, start/data/parity/stop FSM sampling mid-bit,
// parallel byte and sticky-until-next-frame parity/framing flags with a one-cycle done pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 8,
  parameter int DATA_BITS  = 8
) (
  input  logic     clk2,
  input  logic     reset,
  uart_rx_if.slave rx_bus
);

  localparam int BIDX_W = $clog2(DATA_BITS + 1);
  localparam logic [BIDX_W-1:0] LAST_BIT = BIDX_W'(DATA_BITS - 1);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 w_rxs;

  rx_state_t            r_state;
  rx_state_t            w_state_next;
  logic [BIDX_W-1:0]    r_bit_idx;
  logic [BIDX_W-1:0]    w_bit_idx_next;
  logic [DATA_BITS-1:0] r_shreg;
  logic [DATA_BITS-1:0] w_shreg_next;
  logic                 r_pbit;
  logic                 w_pbit_next;

  logic                 w_tick_clr;
  logic                 w_half_tick;
  logic                 w_full_tick;
  logic                 w_frame_end;

  logic [DATA_BITS-1:0] r_data;
  logic                 r_done;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_busy;

  // Synchronizer resets to the idle line level so reset never looks like a start edge.
  always_ff @(posedge clk2 or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_bus.RXdataIn;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs = r_sync2;

  rx_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_timer (
    .clk2        (clk2),
    .reset       (reset),
    .i_clr       (w_tick_clr),
    .o_half_tick (w_half_tick),
    .o_full_tick (w_full_tick)
  );

  // In IDLE the counter is held at 0; the detection cycle itself counts as tick 0 of START.
  always_comb begin
    w_state_next   = r_state;
    w_bit_idx_next = r_bit_idx;
    w_shreg_next   = r_shreg;
    w_pbit_next    = r_pbit;
    w_tick_clr     = 1'b0;
    w_frame_end    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_rxs == START_BIT) begin
          w_state_next = ST_START;
        end else begin
          w_tick_clr = 1'b1;
        end
      end

      ST_START: begin
        if (w_half_tick) begin
          w_tick_clr = 1'b1;
          if (w_rxs == START_BIT) begin
            w_state_next   = ST_DATA;
            w_bit_idx_next = '0;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end

      ST_DATA: begin
        if (w_full_tick) begin
          w_tick_clr     = 1'b1;
          w_shreg_next   = {w_rxs, r_shreg[DATA_BITS-1:1]};
          w_bit_idx_next = r_bit_idx + 1'b1;
          if (r_bit_idx == LAST_BIT) begin
            w_state_next = ST_PARITY;
          end
        end
      end

      ST_PARITY: begin
        if (w_full_tick) begin
          w_tick_clr   = 1'b1;
          w_pbit_next  = w_rxs;
          w_state_next = ST_STOP;
        end
      end

      ST_STOP: begin
        if (w_full_tick) begin
          w_tick_clr   = 1'b1;
          w_frame_end  = 1'b1;
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_tick_clr   = 1'b1;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk2 or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_bit_idx <= '0;
      r_shreg   <= '0;
      r_pbit    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_bit_idx <= w_bit_idx_next;
      r_shreg   <= w_shreg_next;
      r_pbit    <= w_pbit_next;
    end
  end

  // Results are captured on the stop-bit sample; busy tracks the next state so it matches r_state.
  always_ff @(posedge clk2 or negedge reset) begin
    if (!reset) begin
      r_data <= '0;
      r_done <= 1'b0;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_done <= w_frame_end;
      r_busy <= (w_state_next != ST_IDLE);
      if (w_frame_end) begin
        r_data <= r_shreg;
        r_perr <= r_pbit ^ (^r_shreg) ^ ~PARITY_EVEN;
        r_ferr <= (w_rxs != STOP_BIT);
      end
    end
  end

  assign rx_bus.dataOut      = r_data;
  assign rx_bus.RXdone       = r_done;
  assign rx_bus.parityError  = r_perr;
  assign rx_bus.framingError = r_ferr;
  assign rx_bus.RXbusy       = r_busy;

endmodule
